ib_lut_page_loader: RTL

//  Sequences iteration-update writes into the IB-VNU function RAMs (sym_vn_lut_out write port).

---
 rtl/ib_lut_page_loader_pkg.sv | 23 ++
 rtl/ib_lut_load_checksum.sv | 42 ++++
 rtl/ib_lut_page_loader.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ib_lut_page_loader_pkg.sv
// Shared types and constants for the IB-VNU LUT page loader.
// Optional checksum feature is enabled by defining IB_LUT_LOAD_CHECKSUM_EN.
package ib_lut_page_loader_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD      = 2'd1,
      SWAP_WAIT = 2'd2
   } state_t;

   localparam int ENTRY_ADDR_DEF    = 7;
   localparam int BANK_NUM_DEF      = 2;
   localparam int LUT_PORT_SIZE_DEF = 4;
   localparam int ITER_W_DEF        = 5;

   // One RAM half holds one full LUT set; the address MSB selects the half.
   function automatic int page_num(input int entry_addr);
      return 2 ** (entry_addr - 1);
   endfunction

   localparam int PAGE_NUM = page_num(ENTRY_ADDR_DEF);

endpackage

// File: rtl/ib_lut_load_checksum.sv
// XOR accumulator over the written page words, compared with the expected sum on the last write.
// Instantiated only when IB_LUT_LOAD_CHECKSUM_EN is defined.
module ib_lut_load_checksum
   import ib_lut_page_loader_pkg::*;
#(
   parameter int DW = LUT_PORT_SIZE_DEF * BANK_NUM_DEF
)(
   input  logic          clk,
   input  logic          rstn,
   input  logic          i_clear,
   input  logic [DW-1:0] i_exp,
   input  logic          i_beat,
   input  logic [DW-1:0] i_data,
   input  logic          i_last,
   output logic          o_err
);

   logic [DW-1:0] r_sum;
   logic [DW-1:0] r_exp;
   logic [DW-1:0] w_sum_next;

   assign w_sum_next = r_sum ^ i_data;

   // The error flag stays set until the next accepted load clears it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sum <= '0;
         r_exp <= '0;
         o_err <= 1'b0;
      end else if (i_clear) begin
         r_sum <= '0;
         r_exp <= i_exp;
         o_err <= 1'b0;
      end else if (i_beat) begin
         r_sum <= w_sum_next;
         if (i_last) begin
            o_err <= (w_sum_next != r_exp);
         end
      end
   end

endmodule

// File: rtl/ib_lut_page_loader.sv
// Streams LUT pages into the shadow half of the IB-VNU function RAMs and swaps halves on an
// iteration boundary. Define IB_LUT_LOAD_CHECKSUM_EN to add exp_sum/load_err load verification.
module ib_lut_page_loader
   import ib_lut_page_loader_pkg::*;
#(
   parameter int ENTRY_ADDR    = ENTRY_ADDR_DEF,
   parameter int BANK_NUM      = BANK_NUM_DEF,
   parameter int LUT_PORT_SIZE = LUT_PORT_SIZE_DEF,
   parameter int ITER_W        = ITER_W_DEF
)(
   input  logic                              write_clk,
   input  logic                              rstn,
   input  logic                              load_start,
   input  logic [ITER_W-1:0]                 load_iter,
   input  logic                              src_valid,
   input  logic [LUT_PORT_SIZE*BANK_NUM-1:0] src_data,
   output logic                              src_ready,
   input  logic                              iter_boundary,
   output logic [ENTRY_ADDR-1:0]             page_addr_ram,
   output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data_1,
   output logic                              ib_ram_we,
   output logic                              read_addr_offset,
   output logic                              loader_busy,
   output logic                              load_done,
   output logic [ITER_W-1:0]                 active_iter
`ifdef IB_LUT_LOAD_CHECKSUM_EN
  ,input  logic [LUT_PORT_SIZE*BANK_NUM-1:0] exp_sum
  ,output logic                              load_err
`endif
);

   localparam int DW       = LUT_PORT_SIZE * BANK_NUM;
   localparam int CNT_W    = ENTRY_ADDR - 1;
   localparam int PAGES    = page_num(ENTRY_ADDR);
   localparam logic [CNT_W-1:0] LAST_PAGE = CNT_W'(PAGES - 1);

   state_t              r_state, w_state_next;
   logic [CNT_W-1:0]    r_page_cnt, w_page_cnt_next;
   logic [ITER_W-1:0]   r_iter, w_iter_next;

   logic                w_we_next;
   logic [ENTRY_ADDR-1:0] w_addr_next;
   logic [DW-1:0]       w_data_next;
   logic                w_ready_next;
   logic                w_offset_next;
   logic                w_busy_next;
   logic                w_done_next;
   logic [ITER_W-1:0]   w_active_next;

   logic w_accept_start;
   logic w_beat;
   logic w_last;
   logic w_swap_evt;
   logic w_err;

   // load_done is only high in the first IDLE cycle, so this also rejects a start on the swap pulse.
   assign w_accept_start = (r_state == IDLE) && load_start && !load_done;
   assign w_beat         = (r_state == LOAD) && src_valid && src_ready;
   assign w_last         = w_beat && (r_page_cnt == LAST_PAGE);
   // A boundary coinciding with the last write is too early: the page set is not yet in RAM.
   assign w_swap_evt     = (r_state == SWAP_WAIT) && iter_boundary && !ib_ram_we;

`ifdef IB_LUT_LOAD_CHECKSUM_EN
   ib_lut_load_checksum #(
      .DW (DW)
   ) u_checksum (
      .clk     (write_clk),
      .rstn    (rstn),
      .i_clear (w_accept_start),
      .i_exp   (exp_sum),
      .i_beat  (w_beat),
      .i_data  (src_data),
      .i_last  (w_last),
      .o_err   (load_err)
   );
   assign w_err = load_err;
`else
   assign w_err = 1'b0;
`endif

   always_ff @(posedge write_clk or negedge rstn) begin
      if (!rstn) begin
         r_state    <= IDLE;
         r_page_cnt <= '0;
         r_iter     <= '0;
      end else begin
         r_state    <= w_state_next;
         r_page_cnt <= w_page_cnt_next;
         r_iter     <= w_iter_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_page_cnt_next = r_page_cnt;
      w_iter_next     = r_iter;
      w_we_next       = w_beat;
      w_addr_next     = page_addr_ram;
      w_data_next     = ram_write_data_1;
      w_ready_next    = src_ready;
      w_offset_next   = read_addr_offset;
      w_busy_next     = loader_busy;
      w_done_next     = 1'b0;
      w_active_next   = active_iter;

      if (w_beat) begin
         w_addr_next = {~read_addr_offset, r_page_cnt};
         w_data_next = src_data;
      end

      case (r_state)
         IDLE: begin
            if (w_accept_start) begin
               w_state_next    = LOAD;
               w_page_cnt_next = '0;
               w_iter_next     = load_iter;
               w_busy_next     = 1'b1;
               w_ready_next    = 1'b1;
            end
         end
         LOAD: begin
            if (w_beat) begin
               w_page_cnt_next = r_page_cnt + CNT_W'(1);
               if (w_last) begin
                  w_state_next = SWAP_WAIT;
                  w_ready_next = 1'b0;
               end
            end
         end
         SWAP_WAIT: begin
            if (w_swap_evt) begin
               w_state_next = IDLE;
               w_done_next  = 1'b1;
               w_busy_next  = 1'b0;
               if (!w_err) begin
                  w_offset_next = ~read_addr_offset;
                  w_active_next = r_iter;
               end
            end
         end
         default: begin
            w_state_next = IDLE;
            w_ready_next = 1'b0;
            w_busy_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge write_clk or negedge rstn) begin
      if (!rstn) begin
         ib_ram_we        <= 1'b0;
         page_addr_ram    <= '0;
         ram_write_data_1 <= '0;
         src_ready        <= 1'b0;
         read_addr_offset <= 1'b0;
         loader_busy      <= 1'b0;
         load_done        <= 1'b0;
         active_iter      <= '0;
      end else begin
         ib_ram_we        <= w_we_next;
         page_addr_ram    <= w_addr_next;
         ram_write_data_1 <= w_data_next;
         src_ready        <= w_ready_next;
         read_addr_offset <= w_offset_next;
         loader_busy      <= w_busy_next;
         load_done        <= w_done_next;
         active_iter      <= w_active_next;
      end
   end

endmodule
